// File: rtl/five_bit_div_pkg.sv
// Shared definitions for the five_bit_divider restoring divider.
//  - DIV_WIDTH    : default operand / quotient / remainder width
//  - DIV_CNT_W    : iteration counter width for the default width
//  - div_state_t  : FSM state encoding (IDLE, RUN, DONE)
//  - cnt_width()  : counter width for an arbitrary operand width (never below 1 bit)
package five_bit_div_pkg;

    localparam int DIV_WIDTH = 5;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // The counter only has to hold WIDTH-1, so $clog2(WIDTH) bits are enough;
    // the floor of 1 keeps the vector legal for very small widths.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/five_bit_divider_restore_step.sv
// One trial subtraction of the restoring divider (purely combinational).
// Ports:
//  t        in   WIDTH+1  shifted partial remainder with the next dividend bit appended
//  divisor  in   WIDTH    divisor
//  diff     out  WIDTH    t - divisor (low WIDTH bits; only meaningful when ge=1)
//  ge       out  1        t >= divisor, i.e. this quotient bit is 1
module div_restore_step
    import five_bit_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   t,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] diff,
    output logic             ge
);

    // When the subtraction succeeds the result is below the divisor, so it
    // always fits in WIDTH bits and only the low bits of t take part.
    assign ge   = (t >= {1'b0, divisor});
    assign diff = t[WIDTH-1:0] - divisor;

endmodule

// File: rtl/five_bit_divider.sv
// Sequential restoring divider: unsigned dividend / divisor, one trial
// subtraction per clock, start/done handshake.
// Ports:
//  clk, rst_n    clock (rising edge) and asynchronous active-low reset
//  start         request, sampled on the rising edge in IDLE or DONE
//  dividend      numerator, captured on accept
//  divisor       denominator, captured on accept
//  quotient      result, updated on the edge entering DONE
//  remainder     result, updated on the edge entering DONE
//  busy          high while iterating (RUN)
//  done          one-cycle pulse, results valid
//  div_by_zero   last operation had a zero divisor
module five_bit_divider
    import five_bit_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       state;
    div_state_t       next_state;
    logic             accept;

    // Partial remainder. After every restore it is below the divisor, so its
    // extra top bit would always be zero and is not stored.
    logic [WIDTH-1:0] p_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   t_val;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] q_next;

    // Shift the next dividend bit (MSB of Q) into the partial remainder and
    // try subtracting the divisor; the quotient bit enters Q from the right.
    assign t_val  = {p_reg, q_reg[WIDTH-1]};
    assign p_next = ge ? diff : t_val[WIDTH-1:0];
    assign q_next = {q_reg[WIDTH-2:0], ge};

    div_restore_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .t       (t_val),
        .divisor (dvs_reg),
        .diff    (diff),
        .ge      (ge)
    );

    // State register. Reset drops straight to IDLE, which also aborts any
    // operation in flight without producing a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake decode. A zero divisor skips RUN entirely and
    // goes to DONE on the accept edge. start is honoured in DONE as well so a
    // controller can issue operations back to back; in RUN it is ignored.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = (divisor == '0) ? DONE : RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath and result registers. Accept loads the operands and restarts
    // the count but leaves the previous results visible; results change only
    // on the edge that enters DONE (the accept edge itself for a zero divisor,
    // otherwise the last RUN iteration).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg       <= '0;
            q_reg       <= '0;
            dvs_reg     <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            p_reg   <= '0;
            q_reg   <= dividend;
            dvs_reg <= divisor;
            count   <= LAST_CNT;
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            p_reg <= p_next;
            q_reg <= q_next;
            if (count == '0) begin
                quotient    <= q_next;
                remainder   <= p_next;
                div_by_zero <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_five_bit_divider.sv
// Directed self-checking bench for five_bit_divider (WIDTH = 5).
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
module tb_five_bit_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] dividend;
    logic [4:0] divisor;
    logic [4:0] quotient;
    logic [4:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int checks;
    int errors;
    int cycles;
    int busyCycles;
    int doneSeen;

    five_bit_divider #(
        .WIDTH       (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    // 10 ns clock, first rising edge at 5 ns.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case something stalls outside the bounded waits.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One comparison point: counts it, and on a miss counts the failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Offer one operation for exactly one rising edge (E0), then drop start.
    task automatic applyStimulus(input logic [4:0] a, input logic [4:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    // Wait (bounded) for done, counting cycles spent and cycles with busy high.
    task automatic waitDone(output int nCycles, output int nBusy);
        nCycles = 0;
        nBusy   = 0;
        while (!done && nCycles < 20) begin
            if (busy) nBusy++;
            step();
            nCycles++;
        end
    endtask

    // Full operation: issue, wait, check latency and results, then check
    // that done was a single pulse and the results are held in IDLE.
    task automatic doOp(input string tag, input logic [4:0] a, input logic [4:0] b,
                        input int expCycles, input logic [4:0] expQ,
                        input logic [4:0] expR, input logic expDbz);
        applyStimulus(a, b);
        waitDone(cycles, busyCycles);
        checkOutput({tag, "_latency"}, cycles, expCycles);
        checkOutput({tag, "_busy_cycles"}, busyCycles, expCycles);
        checkOutput({tag, "_done"}, done, 1'b1);
        checkOutput({tag, "_busy_at_done"}, busy, 1'b0);
        checkOutput({tag, "_quotient"}, quotient, expQ);
        checkOutput({tag, "_remainder"}, remainder, expR);
        checkOutput({tag, "_dbz"}, div_by_zero, expDbz);
        step();
        checkOutput({tag, "_done_pulse"}, done, 1'b0);
        checkOutput({tag, "_quotient_held"}, quotient, expQ);
        checkOutput({tag, "_dbz_held"}, div_by_zero, expDbz);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state
        step();
        checkOutput("rst_quotient", quotient, 0);
        checkOutput("rst_remainder", remainder, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        step();

        // Normal divisions, including quotient of all ones and dividend < divisor
        doOp("d21_4", 5'd21, 5'd4, 5, 5'd5, 5'd1, 1'b0);
        doOp("d31_1", 5'd31, 5'd1, 5, 5'd31, 5'd0, 1'b0);
        doOp("d7_9", 5'd7, 5'd9, 5, 5'd0, 5'd7, 1'b0);
        doOp("d31_31", 5'd31, 5'd31, 5, 5'd1, 5'd0, 1'b0);

        // Divide by zero: done right after the accept edge, no RUN
        doOp("d13_0", 5'd13, 5'd0, 0, 5'd31, 5'd13, 1'b1);

        // start pulsed in the middle of RUN must be ignored
        applyStimulus(5'd20, 5'd3);
        step();
        step();
        dividend = 5'd9;
        divisor  = 5'd2;
        start    = 1'b1;
        step();
        start    = 1'b0;
        checkOutput("midrun_busy", busy, 1'b1);
        waitDone(cycles, busyCycles);
        checkOutput("midrun_done", done, 1'b1);
        checkOutput("midrun_quotient", quotient, 5'd6);
        checkOutput("midrun_remainder", remainder, 5'd2);
        step();
        checkOutput("midrun_no_restart", busy, 1'b0);

        // start held in DONE: back-to-back accept of 9/2
        applyStimulus(5'd20, 5'd3);
        dividend = 5'd9;
        divisor  = 5'd2;
        waitDone(cycles, busyCycles);
        checkOutput("b2b_first_latency", cycles, 5);
        checkOutput("b2b_first_quotient", quotient, 5'd6);
        checkOutput("b2b_first_remainder", remainder, 5'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("b2b_rerun_busy", busy, 1'b1);
        checkOutput("b2b_rerun_done", done, 1'b0);
        checkOutput("b2b_stale_quotient", quotient, 5'd6);
        waitDone(cycles, busyCycles);
        checkOutput("b2b_second_latency", cycles, 5);
        checkOutput("b2b_second_quotient", quotient, 5'd4);
        checkOutput("b2b_second_remainder", remainder, 5'd1);
        step();

        // Reset asserted on the third RUN cycle aborts without a done pulse
        applyStimulus(5'd30, 5'd7);
        step();
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_quotient", quotient, 0);
        checkOutput("abort_remainder", remainder, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_dbz", div_by_zero, 0);
        #2;
        rst_n = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) doneSeen++;
        end
        checkOutput("abort_no_done", doneSeen, 0);
        doOp("d22_5", 5'd22, 5'd5, 5, 5'd4, 5'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
